disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
//  Upstream driver for the 7-segment display device. Generates the 2-bit digit-scan
//  index (Scanning) and the blink clock (flash_clk) from the system clock.
//  Holds the display registers (disp_num, blinking, pointing) that the device consumes.
//  CPU/bus writes go to a shadow register set. The shadow is committed only at a frame
//  boundary (digit 3 -> 0), so a frame never shows a mix of old and new digits.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot (>= 2)
//  FLASH_DIV  12500000  clk cycles per flash_clk half-period (>= 2)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  scan_en    in   1   1 = scan/commit normally; 0 = freeze scan, writes bypass shadow
//  wr_en      in   1   1-cycle write strobe for wr_data/wr_blink/wr_point
//  wr_data    in   32  new 8-nibble display value
//  wr_blink   in   4   new per-digit blink mask
//  wr_point   in   4   new per-digit decimal-point mask
//  disp_num   out  32  committed display value, to display device
//  blinking   out  4   committed blink mask
//  pointing   out  4   committed point mask
//  Scanning   out  2   current digit index, 0..3
//  flash_clk  out  1   blink square wave, period 2*FLASH_DIV cycles
//  frame_tick out  1   1-cycle pulse in the first cycle after Scanning wraps 3 -> 0
//  pending    out  1   shadow holds data not yet committed
// BEHAVIOUR
//  Reset (async, immediate): every output and internal register goes to 0.
//  - Covers all outputs, shadow registers, scan_cnt and flash_cnt.
//  - Reset mid-frame discards any pending write.
//  scan_cnt: width $clog2(SCAN_DIV).
//  - If scan_en=1: counts 0..SCAN_DIV-1, then wraps to 0.
//  - On the wrap edge, Scanning <= Scanning+1 mod 4, so each digit lasts SCAN_DIV cycles.
//  - If scan_en=0: scan_cnt and Scanning hold their values; frame_tick stays 0.
//  frame edge: the edge where scan_en=1, Scanning=3 and scan_cnt=SCAN_DIV-1.
//  - Scanning becomes 0 on this edge.
//  - frame_tick is registered: it is 1 for exactly the following cycle.
//  - If pending=1: disp_num/blinking/pointing <= shadow and pending <= 0 (same edge).
//  wr_en=1 with scan_en=1: shadow <= {wr_data,wr_blink,wr_point}, pending <= 1.
//  - Later writes before the frame edge overwrite the shadow; last write wins.
//  wr_en=1 on a frame edge while pending=1:
//  - The old shadow is committed.
//  - The new data is captured into the shadow and pending stays 1.
//  wr_en=1 on a frame edge while pending=0: data is captured; pending <= 1; nothing is committed.
//  wr_en=1 with scan_en=0: outputs load directly on that edge (latency 1); pending <= 0.
//  - The shadow is also loaded with the same value.
//  flash_cnt: width $clog2(FLASH_DIV); free-running, independent of scan_en.
//  - Wraps at FLASH_DIV-1; flash_clk toggles on the wrap edge.
//  No combinational path from inputs to outputs; all outputs are registers.
// TESTING  (SCAN_DIV=4, FLASH_DIV=8)
//  1 Release rst -> Scanning 0,1,2,3,0 changing every 4 clks.
//    frame_tick pulses once every 16 clks, 1 cycle wide, when Scanning=0.
//  2 Free run with scan_en toggled -> flash_clk toggles every 8 clks, period 16.
//    flash_clk phase is unaffected by scan_en.
//  3 Write wr_data=32'h12345678 while Scanning=1 -> disp_num stays 0 and pending=1.
//    At the 3->0 edge: disp_num=32'h12345678 and pending=0.
//  4 Write 32'h12345678, then 32'h557EF7E0, within one frame.
//    -> Only 32'h557EF7E0 is committed; 32'h12345678 never appears on disp_num.
//  5 Pending 32'h11111111; write 32'h22222222 on the frame edge.
//    -> disp_num=32'h11111111 and pending=1.
//    -> At the next frame edge, disp_num=32'h22222222 and pending=0.
//  6 scan_en=0, write wr_blink=4'b1010 -> blinking=4'b1010 one clk later; Scanning frozen.
//    Then assert rst mid-frame -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Scan-index/blink generator holding double-buffered display registers; committed values swap in at the 3->0 frame edge.
// Latency: writes show on the outputs at the next frame edge, or one clk later when scan_en=0; no backpressure, so writes are always accepted.
module disp_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int FLASH_DIV = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_blink,
    input  logic [3:0]  wr_point,
    output logic [31:0] disp_num,
    output logic [3:0]  blinking,
    output logic [3:0]  pointing,
    output logic [1:0]  Scanning,
    output logic        flash_clk,
    output logic        frame_tick,
    output logic        pending
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FLASH_W = $clog2(FLASH_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

    typedef struct packed {
        logic [31:0] num;
        logic [3:0]  blink;
        logic [3:0]  point;
    } disp_t;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [FLASH_W-1:0] flash_cnt;
    logic               scan_wrap;
    logic               frame_edge;
    logic               flash_wrap;
    disp_t              wr_word;
    disp_t              shadow;
    disp_t              live;

    assign wr_word    = {wr_data, wr_blink, wr_point};
    assign scan_wrap  = scan_en && (scan_cnt == SCAN_LAST);
    assign frame_edge = scan_wrap && (Scanning == 2'd3);
    assign flash_wrap = (flash_cnt == FLASH_LAST);

    assign disp_num = live.num;
    assign blinking = live.blink;
    assign pointing = live.point;

    // Digit scan: scan_en=0 freezes both the slot counter and the digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt   <= '0;
            Scanning   <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_edge;
            if (scan_en) begin
                if (scan_wrap) begin
                    scan_cnt <= '0;
                    Scanning <= Scanning + 2'd1;
                end else begin
                    scan_cnt <= scan_cnt + SCAN_W'(1);
                end
            end
        end
    end

    // Blink clock runs regardless of scan_en so its phase never drifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= '0;
            flash_clk <= 1'b0;
        end else if (flash_wrap) begin
            flash_cnt <= '0;
            flash_clk <= ~flash_clk;
        end else begin
            flash_cnt <= flash_cnt + FLASH_W'(1);
        end
    end

    // Commit uses the old shadow, so a write landing on the frame edge
    // queues behind the value being committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            live    <= '0;
            pending <= 1'b0;
        end else if (wr_en && !scan_en) begin
            shadow  <= wr_word;
            live    <= wr_word;
            pending <= 1'b0;
        end else begin
            if (frame_edge && pending) begin
                live <= shadow;
            end
            if (wr_en) begin
                shadow  <= wr_word;
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a cycle-level model built on position counters plus
// directed literal checks of the scan, blink, commit and reset behaviour.
module tb_disp_scan_ctrl;

    localparam int SD    = 4;
    localparam int FD    = 8;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_en = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_blink = '0;
    logic [3:0]  wr_point = '0;
    logic [31:0] disp_num;
    logic [3:0]  blinking;
    logic [3:0]  pointing;
    logic [1:0]  Scanning;
    logic        flash_clk;
    logic        frame_tick;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;

    disp_scan_ctrl #(.SCAN_DIV(SD), .FLASH_DIV(FD)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .wr_en(wr_en),
        .wr_data(wr_data), .wr_blink(wr_blink), .wr_point(wr_point),
        .disp_num(disp_num), .blinking(blinking), .pointing(pointing),
        .Scanning(Scanning), .flash_clk(flash_clk), .frame_tick(frame_tick),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Model: p = enabled cycles within the frame, c = cycles within the flash period.
    int          p, c;
    logic        m_ft, m_pend;
    logic [31:0] m_num, s_num;
    logic [3:0]  m_blink, s_blink, m_point, s_point;
    logic        m_fe;

    assign m_fe = scan_en && (p == FRAME - 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= 0; c <= 0; m_ft <= 1'b0; m_pend <= 1'b0;
            m_num <= '0; m_blink <= '0; m_point <= '0;
            s_num <= '0; s_blink <= '0; s_point <= '0;
        end else begin
            m_ft <= m_fe;
            if (scan_en) p <= (p + 1) % FRAME;
            c <= (c + 1) % (2 * FD);
            if (wr_en && !scan_en) begin
                m_num <= wr_data; m_blink <= wr_blink; m_point <= wr_point;
                s_num <= wr_data; s_blink <= wr_blink; s_point <= wr_point;
                m_pend <= 1'b0;
            end else begin
                if (m_fe && m_pend) begin
                    m_num <= s_num; m_blink <= s_blink; m_point <= s_point;
                end
                if (wr_en) begin
                    s_num <= wr_data; s_blink <= wr_blink; s_point <= wr_point;
                    m_pend <= 1'b1;
                end else if (m_fe) begin
                    m_pend <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_disp_num", disp_num, m_num);
        chk("m_blinking", 32'(blinking), 32'(m_blink));
        chk("m_pointing", 32'(pointing), 32'(m_point));
        chk("m_scanning", 32'(Scanning), 32'(p / SD));
        chk("m_flash_clk", 32'(flash_clk), 32'(c / FD));
        chk("m_frame_tick", 32'(frame_tick), 32'(m_ft));
        chk("m_pending", 32'(pending), 32'(m_pend));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] b, input logic [3:0] pt);
        wr_en = 1'b1; wr_data = d; wr_blink = b; wr_point = pt;
        step(1);
        wr_en = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        // n counts rising edges since reset release
        chk("rst_scanning", 32'(Scanning), 32'd0);
        chk("rst_disp", disp_num, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_flash", 32'(flash_clk), 32'd0);
        step(4);   // n=4
        chk("scan_n4", 32'(Scanning), 32'd1);
        step(11);  // n=15
        chk("scan_n15", 32'(Scanning), 32'd3);
        chk("ft_n15", 32'(frame_tick), 32'd0);
        chk("flash_n15", 32'(flash_clk), 32'd1);
        step(1);   // n=16
        chk("scan_n16", 32'(Scanning), 32'd0);
        chk("ft_n16", 32'(frame_tick), 32'd1);
        chk("flash_n16", 32'(flash_clk), 32'd0);

        // Two writes in one frame: only the last is ever committed.
        step(1);   // n=17
        wr(32'h12345678, 4'h0, 4'h0);
        wr(32'h557EF7E0, 4'h3, 4'h5);  // n=19
        chk("lastwin_pend", 32'(pending), 32'd1);
        chk("lastwin_hold", disp_num, 32'd0);
        for (int i = 0; i < 13; i++) begin
            step(1);
            n_cmp++;
            if (disp_num === 32'h12345678) begin
                n_bad++;
                $display("FAIL lastwin_never_old: got %h at %0t", disp_num, $time);
            end
        end        // n=32
        chk("lastwin_commit", disp_num, 32'h557EF7E0);
        chk("lastwin_pend0", 32'(pending), 32'd0);

        // Write during digit 1, committed at next 3->0.
        step(4);   // n=36
        chk("t3_scan1", 32'(Scanning), 32'd1);
        wr(32'h12345678, 4'h0, 4'h0);  // n=37
        chk("t3_hold", disp_num, 32'h557EF7E0);
        chk("t3_pend", 32'(pending), 32'd1);
        step(11);  // n=48
        chk("t3_commit", disp_num, 32'h12345678);
        chk("t3_pend0", 32'(pending), 32'd0);

        // Write landing on the frame edge while another write is pending.
        step(1);   // n=49
        wr(32'h11111111, 4'h0, 4'h0);  // n=50
        step(13);  // n=63
        wr(32'h22222222, 4'h0, 4'h0);  // n=64, frame edge
        chk("t5_commit_old", disp_num, 32'h11111111);
        chk("t5_pend", 32'(pending), 32'd1);
        step(16);  // n=80
        chk("t5_commit_new", disp_num, 32'h22222222);
        chk("t5_pend0", 32'(pending), 32'd0);
        chk("flash_n80", 32'(flash_clk), 32'd0);

        // Frozen scan: direct load, Scanning holds.
        scan_en = 1'b0;
        wr(32'h22222222, 4'b1010, 4'h0);  // n=81
        chk("t6_blink", 32'(blinking), 32'b1010);
        chk("t6_pend", 32'(pending), 32'd0);
        step(3);   // n=84
        chk("t6_frozen", 32'(Scanning), 32'd0);
        chk("flash_n84", 32'(flash_clk), 32'd0);
        step(4);   // n=88
        chk("flash_n88", 32'(flash_clk), 32'd1);

        // Random traffic with scan_en toggling.
        for (int i = 0; i < 2000; i++) begin
            scan_en  = ($urandom_range(0, 7) != 0);
            wr_en    = ($urandom_range(0, 4) == 0);
            wr_data  = $urandom;
            wr_blink = 4'($urandom);
            wr_point = 4'($urandom);
            step(1);
        end

        // Async reset mid-cycle with non-zero outputs.
        scan_en = 1'b0;
        wr(32'hDEADBEEF, 4'hF, 4'hF);
        scan_en = 1'b1;
        wr(32'hCAFEF00D, 4'h1, 4'h2);
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_disp", disp_num, 32'd0);
        chk("arst_blink", 32'(blinking), 32'd0);
        chk("arst_point", 32'(pointing), 32'd0);
        chk("arst_pend", 32'(pending), 32'd0);
        chk("arst_scan", 32'(Scanning), 32'd0);
        chk("arst_ft", 32'(frame_tick), 32'd0);
        chk("arst_flash", 32'(flash_clk), 32'd0);
        step(3);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            scan_en  = ($urandom_range(0, 5) != 0);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_data  = $urandom;
            wr_blink = 4'($urandom);
            wr_point = 4'($urandom);
            step(1);
        end
        wr_en = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
